// File: rtl/fuzzy_pkg.sv
// Shared fuzzy-chain definitions: width helpers, defuzzifier FSM states and
// the µ / crisp scale constants used by both the fuzzifier and the defuzzifier.
package fuzzy_pkg;

  localparam int MU_MAX    = 255;
  localparam int CRISP_MAX = 100;

  typedef enum logic [1:0] {
    ACUM,
    DIV,
    FIM
  } estado_t;

  function automatic int num_w(input int num_max);
    return 16 + $clog2(num_max);
  endfunction

  function automatic int den_w(input int num_max);
    return 8 + $clog2(num_max);
  endfunction

endpackage

// File: rtl/divisor_seq.sv
// Bit-serial restoring divider: one quotient bit per cycle, ITER cycles after i_start.
// Numerator bits above ITER are preloaded into the remainder and must be < i_den.
module divisor_seq #(
  parameter int NUM_W = 20,
  parameter int DEN_W = 12,
  parameter int ITER  = 20,
  parameter int QUO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_busy,
  output logic             o_done,
  output logic [QUO_W-1:0] o_quo
);

  localparam int CNT_W = $clog2(ITER + 1);

  logic [DEN_W:0]   r_rem;
  logic [ITER-1:0]  r_quo;
  logic [DEN_W-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [DEN_W:0]   w_num_hi;
  logic [DEN_W:0]   w_rem_sh;
  logic [DEN_W:0]   w_rem_nx;
  logic             w_ge;

  // Extra numerator bits (rounding mode) are absorbed into the first shift.
  generate
    if (NUM_W > ITER) begin : g_pre
      assign w_num_hi = (DEN_W+1)'(i_num[NUM_W-1:ITER]);
    end else begin : g_nopre
      assign w_num_hi = '0;
    end
  endgenerate

  always_comb begin
    w_rem_sh = {r_rem[DEN_W-1:0], r_quo[ITER-1]};
    w_ge     = (w_rem_sh >= {1'b0, r_den});
    w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_den}) : w_rem_sh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_den  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_rem  <= w_num_hi;
        r_quo  <= i_num[ITER-1:0];
        r_den  <= i_den;
        r_cnt  <= CNT_W'(ITER);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_rem_nx;
        r_quo <= {r_quo[ITER-2:0], w_ge};
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_quo  = r_quo[QUO_W-1:0];

endmodule

// File: rtl/defuzz_centroide.sv
// Centroid defuzzifier: accumulates Σ(µ·c) and Σµ per frame, then divides serially.
// Define DEFUZZ_ARRED_EN for round-to-nearest instead of floor division.
module defuzz_centroide
  import fuzzy_pkg::*;
#(
  parameter int NUM_MAX      = 16,
  parameter int VALOR_PADRAO = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entrada_valida,
  output logic       entrada_pronta,
  input  logic [7:0] grau_pertinencia,
  input  logic [7:0] centro,
  input  logic       ultimo,
  output logic       saida_valida,
  input  logic       saida_pronta,
  output logic [7:0] valor_crisp,
  output logic       sem_regra,
  output logic       erro_excesso
);

  localparam int NUM_W = num_w(NUM_MAX);
  localparam int DEN_W = den_w(NUM_MAX);
  localparam int CNT_W = $clog2(NUM_MAX) + 1;
`ifdef DEFUZZ_ARRED_EN
  localparam int DIVN_W = NUM_W + 1;
`else
  localparam int DIVN_W = NUM_W;
`endif

  estado_t          r_estado;
  logic [NUM_W-1:0] r_num;
  logic [DEN_W-1:0] r_den;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pronta;
  logic             r_valido;
  logic [7:0]       r_crisp;
  logic             r_sem;
  logic             r_erro;

  logic [15:0]       w_prod;
  logic [NUM_W-1:0]  w_num_nx;
  logic [DEN_W-1:0]  w_den_nx;
  logic [DIVN_W-1:0] w_div_num;
  logic              w_aceita;
  logic              w_limite;
  logic              w_fecha;
  logic              w_start;
  logic              w_div_busy;
  logic              w_div_done;
  logic [7:0]        w_quo;

  always_comb begin
    w_prod   = 16'(grau_pertinencia) * 16'(centro);
    w_num_nx = r_num + NUM_W'(w_prod);
    w_den_nx = r_den + DEN_W'(grau_pertinencia);
`ifdef DEFUZZ_ARRED_EN
    w_div_num = DIVN_W'(w_num_nx) + DIVN_W'(w_den_nx >> 1);
`else
    w_div_num = w_num_nx;
`endif
    w_aceita = entrada_valida & r_pronta;
    w_limite = (r_cnt == CNT_W'(NUM_MAX - 1));
    w_fecha  = w_aceita & (ultimo | w_limite);
    w_start  = w_fecha & ~w_div_busy;
  end

  // The divider is loaded from the post-beat sums on the closing edge so the
  // result lands NUM_W+1 edges after the last beat.
  divisor_seq #(
    .NUM_W (DIVN_W),
    .DEN_W (DEN_W),
    .ITER  (NUM_W),
    .QUO_W (8)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_num   (w_div_num),
    .i_den   (w_den_nx),
    .o_busy  (w_div_busy),
    .o_done  (w_div_done),
    .o_quo   (w_quo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= ACUM;
      r_num    <= '0;
      r_den    <= '0;
      r_cnt    <= '0;
      r_pronta <= 1'b1;
      r_valido <= 1'b0;
      r_crisp  <= '0;
      r_sem    <= 1'b0;
      r_erro   <= 1'b0;
    end else begin
      case (r_estado)
        ACUM: begin
          if (w_aceita) begin
            r_num <= w_num_nx;
            r_den <= w_den_nx;
            r_cnt <= r_cnt + 1'b1;
            if (w_fecha) begin
              r_estado <= DIV;
              r_pronta <= 1'b0;
              if (!ultimo) r_erro <= 1'b1;
            end
          end
        end
        DIV: begin
          if (w_div_done) begin
            r_estado <= FIM;
            r_valido <= 1'b1;
            if (r_den == '0) begin
              r_crisp <= 8'(VALOR_PADRAO);
              r_sem   <= 1'b1;
            end else begin
              r_crisp <= w_quo;
              r_sem   <= 1'b0;
            end
          end
        end
        FIM: begin
          if (saida_pronta) begin
            r_estado <= ACUM;
            r_valido <= 1'b0;
            r_pronta <= 1'b1;
            r_num    <= '0;
            r_den    <= '0;
            r_cnt    <= '0;
            r_sem    <= 1'b0;
            r_erro   <= 1'b0;
          end
        end
        default: r_estado <= ACUM;
      endcase
    end
  end

  assign entrada_pronta = r_pronta;
  assign saida_valida   = r_valido;
  assign valor_crisp    = r_crisp;
  assign sem_regra      = r_sem;
  assign erro_excesso   = r_erro;

endmodule
